// File: rtl/run_controller.sv
// Run-control and end-of-test detector for the RV32I core: holds the core in reset,
// counts RUN cycles, and latches a sticky verdict from tohost, halt, pc-stall or timeout.
module run_controller #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned RESET_HOLD  = 2,
    parameter int unsigned MAX_CYCLES  = 200,
    parameter int unsigned NUM_HALT    = 2,
    parameter int unsigned STALL_LIMIT = 4,
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                restart,
    input  logic [31:0]         pc,
    input  logic                mem_we,
    input  logic [31:0]         mem_addr,
    input  logic [31:0]         mem_wdata,
    input  logic [NUM_HALT-1:0] halt_req,
    output logic                core_reset_n,
    output logic                running,
    output logic                done,
    output logic                pass,
    output logic [2:0]          status,
    output logic [30:0]         exit_code,
    output logic [CNT_W-1:0]    cycle_count
);

    if (RESET_HOLD < 1) begin : g_bad_hold
        $error("run_controller: RESET_HOLD must be at least 1");
    end
    if (NUM_HALT < 1 || NUM_HALT > 8) begin : g_bad_halt
        $error("run_controller: NUM_HALT must be in 1..8");
    end
    if (CNT_W < 1 || CNT_W > 63) begin : g_bad_cnt_w
        $error("run_controller: CNT_W must be in 1..63");
    end
    if (64'(MAX_CYCLES) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_max
        $error("run_controller: MAX_CYCLES does not fit in cycle_count");
    end

    localparam logic [2:0] ST_NONE    = 3'd0;
    localparam logic [2:0] ST_TOHOST  = 3'd1;
    localparam logic [2:0] ST_HALT    = 3'd2;
    localparam logic [2:0] ST_STALL   = 3'd3;
    localparam logic [2:0] ST_TIMEOUT = 3'd4;

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_d;
    logic [31:0] hold_cnt;
    logic [31:0] stall_cnt;
    logic [31:0] pc_q;
    logic [2:0]  halt_idx;
    logic        first_cycle;
    logic        ev_tohost;
    logic        ev_halt;
    logic        ev_stall;
    logic        ev_timeout;
    logic        hold_last;
    logic [2:0]  term_status;
    logic        term_pass;
    logic [30:0] term_exit;

    // cycle_count saturates and never wraps, so zero marks only the first RUN cycle
    assign first_cycle = (cycle_count == '0);
    assign hold_last   = (hold_cnt == 32'(RESET_HOLD - 1));

    always_comb begin
        halt_idx = '0;
        for (int i = int'(NUM_HALT) - 1; i >= 0; i--) begin
            if (halt_req[i]) halt_idx = 3'(i);
        end
    end

    assign ev_tohost  = mem_we && (mem_addr == TOHOST_ADDR) && mem_wdata[0];
    assign ev_halt    = |halt_req;
    assign ev_stall   = (STALL_LIMIT != 0) && !first_cycle && (pc == pc_q)
                        && (stall_cnt == 32'(STALL_LIMIT - 1));
    assign ev_timeout = (MAX_CYCLES != 0) && (cycle_count == CNT_W'(MAX_CYCLES - 1));

    always_comb begin
        term_status = ST_NONE;
        term_pass   = 1'b0;
        term_exit   = '0;
        if (ev_tohost) begin
            term_status = ST_TOHOST;
            term_pass   = (mem_wdata == 32'd1);
            term_exit   = mem_wdata[31:1];
        end else if (ev_halt) begin
            term_status = ST_HALT;
            term_exit   = {28'd0, halt_idx};
        end else if (ev_stall) begin
            term_status = ST_STALL;
            term_exit   = pc_q[31:1];
        end else if (ev_timeout) begin
            term_status = ST_TIMEOUT;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            S_HOLD:  if (hold_last) state_d = S_RUN;
            S_RUN:   if (term_status != ST_NONE) state_d = S_DONE;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_HOLD;
        endcase
        if (restart) state_d = S_HOLD;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_HOLD;
        else       state <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt     <= '0;
            stall_cnt    <= '0;
            pc_q         <= '0;
            core_reset_n <= 1'b0;
            running      <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            status       <= ST_NONE;
            exit_code    <= '0;
            cycle_count  <= '0;
        end else if (restart) begin
            hold_cnt     <= '0;
            stall_cnt    <= '0;
            pc_q         <= '0;
            core_reset_n <= 1'b0;
            running      <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            status       <= ST_NONE;
            exit_code    <= '0;
            cycle_count  <= '0;
        end else begin
            unique case (state)
                S_HOLD: begin
                    hold_cnt <= hold_cnt + 32'd1;
                    if (hold_last) begin
                        core_reset_n <= 1'b1;
                        running      <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
                    pc_q <= pc;
                    if (first_cycle || (pc != pc_q)) stall_cnt <= '0;
                    else if (stall_cnt != '1)        stall_cnt <= stall_cnt + 32'd1;
                    if (term_status != ST_NONE) begin
                        done      <= 1'b1;
                        running   <= 1'b0;
                        status    <= term_status;
                        pass      <= term_pass;
                        exit_code <= term_exit;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
